// File: rtl/multisum_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : multisum_scheduler_if
// Description : Requester-side and MultiSum-side bus of multisum_scheduler.
//               The master modport is the environment (requesters plus the
//               MultiSum instance). The slave modport is the scheduler.
// Revision    : 1.0  initial release
// ============================================================================
interface multisum_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*4*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]          ack;
  logic [DATA_W-1:0]           result;
  logic [2:0]                  grant_id;
  logic                        busy;
  logic                        err;
  logic [DATA_W-1:0]           ms_in0;
  logic [DATA_W-1:0]           ms_in1;
  logic [DATA_W-1:0]           ms_in2;
  logic [DATA_W-1:0]           ms_in3;
  logic                        ms_start;
  logic [DATA_W-1:0]           ms_sum;
  logic                        ms_done;

  modport master (
    output req, req_data, ms_sum, ms_done,
    input  ack, result, grant_id, busy, err,
    input  ms_in0, ms_in1, ms_in2, ms_in3, ms_start
  );

  modport slave (
    input  req, req_data, ms_sum, ms_done,
    output ack, result, grant_id, busy, err,
    output ms_in0, ms_in1, ms_in2, ms_in3, ms_start
  );
endinterface
`default_nettype wire

// File: rtl/multisum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : multisum_scheduler
// Description : Round-robin arbiter/sequencer sharing one MultiSum adder
//               between NUM_REQ requesters. Grants one requester, loads its
//               four operands, pulses ms_start, waits for a rising edge of
//               ms_done and returns the sum with a one-cycle one-hot ack.
//               Optional watchdog: define MSCHED_TIMEOUT_EN to abort WAIT
//               after TIMEOUT cycles with result = 0 and err = 1.
// Revision    : 1.0  initial release
// ============================================================================
module multisum_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  multisum_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_rr_ptr;
  logic                r_done_q;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_result;
  logic [2:0]          r_grant_id;
  logic                r_busy;
  logic                r_ms_start;
  logic [DATA_W-1:0]   r_ms_in0;
  logic [DATA_W-1:0]   r_ms_in1;
  logic [DATA_W-1:0]   r_ms_in2;
  logic [DATA_W-1:0]   r_ms_in3;

`ifdef MSCHED_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  logic                r_err;
  logic [c_cnt_w-1:0]  r_wd_cnt;
`endif

  logic                w_any;
  logic [2:0]          w_pick;
  logic                w_found_hi;
  logic [2:0]          w_pick_hi;
  logic                w_found_lo;
  logic [2:0]          w_pick_lo;
  logic                w_done_edge;
  logic [DATA_W-1:0]   w_word [NUM_REQ][4];
  logic [DATA_W-1:0]   w_sel  [4];

  // Split the flat operand bus into per-requester words (in0 is the LSB word).
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack_req
    for (genvar w = 0; w < 4; w++) begin : g_unpack_word
      assign w_word[k][w] = bus.req_data[(k*4 + w)*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: lowest set bit at or above rr_ptr, else lowest set bit overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = 3'd0;
    w_found_lo = 1'b0;
    w_pick_lo  = 3'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (bus.req[j] && !w_found_hi && (3'(j) >= r_rr_ptr)) begin
        w_found_hi = 1'b1;
        w_pick_hi  = 3'(j);
      end
      if (bus.req[j] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_pick_lo  = 3'(j);
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    w_any  = |bus.req;
  end

  // Operand mux for the requester about to be granted.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      w_sel[w] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick == 3'(k)) begin
        for (int w = 0; w < 4; w++) begin
          w_sel[w] = w_word[k][w];
        end
      end
    end
  end

  // ms_done history, so a level held over from an earlier operation is not a completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= bus.ms_done;
    end
  end

  assign w_done_edge = bus.ms_done & ~r_done_q;

  // Sequencer: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 3'd0;
      r_ack      <= '0;
      r_result   <= '0;
      r_grant_id <= 3'd0;
      r_busy     <= 1'b0;
      r_ms_start <= 1'b0;
      r_ms_in0   <= '0;
      r_ms_in1   <= '0;
      r_ms_in2   <= '0;
      r_ms_in3   <= '0;
`ifdef MSCHED_TIMEOUT_EN
      r_err      <= 1'b0;
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_ack      <= '0;
      r_ms_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_pick;
            r_ms_in0   <= w_sel[0];
            r_ms_in1   <= w_sel[1];
            r_ms_in2   <= w_sel[2];
            r_ms_in3   <= w_sel[3];
            r_busy     <= 1'b1;
            r_ms_start <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef MSCHED_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done_edge) begin
            r_result <= bus.ms_sum;
            r_ack    <= NUM_REQ'(1) << r_grant_id;
`ifdef MSCHED_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
            r_state  <= S_RESP;
          end
`ifdef MSCHED_TIMEOUT_EN
          else if (r_wd_cnt == c_cnt_w'(TIMEOUT - 1)) begin
            r_result <= '0;
            r_ack    <= NUM_REQ'(1) << r_grant_id;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_rr_ptr <= (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
          r_busy   <= 1'b0;
`ifdef MSCHED_TIMEOUT_EN
          r_err    <= 1'b0;
`endif
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.result   = r_result;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;
  assign bus.ms_start = r_ms_start;
  assign bus.ms_in0   = r_ms_in0;
  assign bus.ms_in1   = r_ms_in1;
  assign bus.ms_in2   = r_ms_in2;
  assign bus.ms_in3   = r_ms_in3;
`ifdef MSCHED_TIMEOUT_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule
`default_nettype wire
